// File: rtl/matrix_gen.sv
// Character-matrix address generator: video counter, row base, row counter and display/idle state.
// Build option MATRIX_HIRES_EN adds the double-rate (80-column) counter hvc; without it hvc is 0.

module matrix_gen #(
    parameter int VC_W          = 10,
    parameter int RC_W          = 3,
    parameter int RC_MAX        = 7,
    parameter int CYC_LOAD      = 13,
    parameter int CYC_INC_FIRST = 15,
    parameter int CYC_INC_LAST  = 54,
    parameter int CYC_ROW_END   = 57
) (
    input  logic            clk_dot4x,
    input  logic            rst,
    input  logic            clk_phi,
    input  logic            phi_phase_start_1,
    input  logic            phi_phase_start_8,
    input  logic            phi_phase_start_14,
    input  logic [6:0]      cycle_num,
    input  logic [8:0]      raster_line,
    input  logic            badline,
    input  logic            hires_en,
    output logic            idle,
    output logic [VC_W-1:0] vc,
    output logic [VC_W-1:0] vc_base,
    output logic [RC_W-1:0] rc,
    output logic            row_start,
    output logic [VC_W:0]   hvc
);

    localparam int RC_LIMIT = (1 << RC_W) - 1;

    if (!(1 < CYC_LOAD && CYC_LOAD < CYC_INC_FIRST && CYC_INC_FIRST <= CYC_INC_LAST &&
          CYC_INC_LAST < CYC_ROW_END && CYC_ROW_END <= 127)) begin : g_bad_cycles
        $error("matrix_gen: raster cycle parameters out of order or above 127");
    end

    if (RC_MAX < 1 || RC_MAX > RC_LIMIT) begin : g_bad_rc_max
        $error("matrix_gen: RC_MAX must lie in 1..2^RC_W-1");
    end

    localparam logic [6:0]      C_LOAD      = 7'(CYC_LOAD);
    localparam logic [6:0]      C_INC_FIRST = 7'(CYC_INC_FIRST);
    localparam logic [6:0]      C_INC_LAST  = 7'(CYC_INC_LAST);
    localparam logic [6:0]      C_ROW_END   = 7'(CYC_ROW_END);
    localparam logic [RC_W-1:0] RC_LAST     = RC_W'(RC_MAX);

    // Display/idle state; idle is the state register itself.
    localparam logic [0:0] ST_DISPLAY = 1'b0;
    localparam logic [0:0] ST_IDLE    = 1'b1;

    logic            e1;
    logic            e14;
    logic            frame_start;
    logic            in_window;
    logic            cyc_load;
    logic            cyc_row_end;
    logic            rc_at_last;

    logic [0:0]      state_q;
    logic [0:0]      state_n;
    logic [VC_W-1:0] vc_q;
    logic [VC_W-1:0] vc_n;
    logic [VC_W-1:0] vc_base_q;
    logic [VC_W-1:0] vc_base_n;
    logic [RC_W-1:0] rc_q;
    logic [RC_W-1:0] rc_n;
    logic            row_start_q;
    logic            row_start_n;

    assign e1  = clk_phi & phi_phase_start_1;
    assign e14 = clk_phi & phi_phase_start_14;

    // Cycle decodes are only consulted when e1 is true.
    assign frame_start = (cycle_num == 7'd1) && (raster_line == 9'd0);
    assign in_window   = (cycle_num >= C_INC_FIRST) && (cycle_num <= C_INC_LAST);
    assign cyc_load    = (cycle_num == C_LOAD);
    assign cyc_row_end = (cycle_num == C_ROW_END);
    assign rc_at_last  = (rc_q == RC_LAST);

    always_comb begin
        state_n     = state_q;
        vc_n        = vc_q;
        vc_base_n   = vc_base_q;
        rc_n        = rc_q;
        row_start_n = 1'b0;

        if (e1) begin
            if (frame_start) begin
                vc_n      = '0;
                vc_base_n = '0;
            end
            if (in_window && state_q == ST_DISPLAY) begin
                vc_n = vc_q + 1'b1;
            end
            if (cyc_load) begin
                vc_n        = vc_base_q;
                row_start_n = 1'b1;
                if (badline) begin
                    rc_n = '0;
                end
            end
            // The advance test deliberately sees the idle value just set by the row wrap.
            if (cyc_row_end) begin
                if (rc_at_last) begin
                    vc_base_n = vc_q;
                    state_n   = ST_IDLE;
                end
                if (state_n == ST_DISPLAY || badline) begin
                    rc_n    = rc_at_last ? '0 : rc_q + 1'b1;
                    state_n = ST_DISPLAY;
                end
            end
        end

        if (e14 && badline) begin
            state_n = ST_DISPLAY;
        end
    end

    always_ff @(posedge clk_dot4x or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            vc_q        <= '0;
            vc_base_q   <= '0;
            rc_q        <= RC_LAST;
            row_start_q <= 1'b0;
        end else begin
            state_q     <= state_n;
            vc_q        <= vc_n;
            vc_base_q   <= vc_base_n;
            rc_q        <= rc_n;
            row_start_q <= row_start_n;
        end
    end

    assign idle      = state_q[0];
    assign vc        = vc_q;
    assign vc_base   = vc_base_q;
    assign rc        = rc_q;
    assign row_start = row_start_q;

`ifdef MATRIX_HIRES_EN
    logic          e8;
    logic [VC_W:0] hvc_q;
    logic [VC_W:0] hvc_n;
    logic [VC_W:0] hvc_base_q;
    logic [VC_W:0] hvc_base_n;
    logic          hvc_win_q;
    logic          hvc_win_n;

    assign e8 = clk_phi & phi_phase_start_8;

    // cycle_num is only trusted at phase 1, so the window seen at e8 is the one latched at e1.
    always_comb begin
        hvc_n      = hvc_q;
        hvc_base_n = hvc_base_q;
        hvc_win_n  = hvc_win_q;

        if (e1) begin
            hvc_win_n = in_window;
            if (frame_start) begin
                hvc_n      = '0;
                hvc_base_n = '0;
            end
            if (hires_en && in_window && state_q == ST_DISPLAY) begin
                hvc_n = hvc_q + 1'b1;
            end
            if (cyc_load) begin
                hvc_n = hvc_base_q;
            end
            if (cyc_row_end && rc_at_last) begin
                hvc_base_n = hvc_q;
            end
        end

        if (e8 && hires_en && hvc_win_q && state_q == ST_DISPLAY) begin
            hvc_n = hvc_q + 1'b1;
        end
    end

    always_ff @(posedge clk_dot4x or posedge rst) begin
        if (rst) begin
            hvc_q      <= '0;
            hvc_base_q <= '0;
            hvc_win_q  <= 1'b0;
        end else begin
            hvc_q      <= hvc_n;
            hvc_base_q <= hvc_base_n;
            hvc_win_q  <= hvc_win_n;
        end
    end

    assign hvc = hvc_q;
`else
    logic unused_hires;

    assign unused_hires = phi_phase_start_8 ^ hires_en;
    assign hvc          = '0;
`endif

endmodule

// File: tb/tb_matrix_gen.sv
// Directed bench for matrix_gen: stimulus tasks push expectations, a negedge monitor pops and compares.
// Loads are checked whenever row_start is seen; state snapshots are checked on explicit requests.

module tb_matrix_gen;

  localparam int VC_W   = 10;
  localparam int RC_W   = 3;
  localparam int C_LOAD = 13;
`ifdef MATRIX_HIRES_EN
  localparam int HIRES = 1;
`else
  localparam int HIRES = 0;
`endif

  localparam logic [3:0] SEL_VC   = 4'd0;
  localparam logic [3:0] SEL_VCB  = 4'd1;
  localparam logic [3:0] SEL_RC   = 4'd2;
  localparam logic [3:0] SEL_IDLE = 4'd3;
  localparam logic [3:0] SEL_HVC  = 4'd4;

  logic            clk_dot4x = 1'b0;
  logic            rst;
  logic            clk_phi;
  logic            phi_phase_start_1;
  logic            phi_phase_start_8;
  logic            phi_phase_start_14;
  logic [6:0]      cycle_num;
  logic [8:0]      raster_line;
  logic            badline;
  logic            hires_en;
  logic            idle;
  logic [VC_W-1:0] vc;
  logic [VC_W-1:0] vc_base;
  logic [RC_W-1:0] rc;
  logic            row_start;
  logic [VC_W:0]   hvc;

  logic [15:0]     exp_q[$];
  string           name_q[$];
  logic [VC_W-1:0] load_q[$];
  logic            chk_req = 1'b0;
  int              checks = 0;
  int              errors = 0;

  matrix_gen #(
    .VC_W(VC_W), .RC_W(RC_W), .RC_MAX(7), .CYC_LOAD(C_LOAD),
    .CYC_INC_FIRST(15), .CYC_INC_LAST(54), .CYC_ROW_END(57)
  ) dut (
    .clk_dot4x(clk_dot4x), .rst(rst), .clk_phi(clk_phi),
    .phi_phase_start_1(phi_phase_start_1), .phi_phase_start_8(phi_phase_start_8),
    .phi_phase_start_14(phi_phase_start_14), .cycle_num(cycle_num),
    .raster_line(raster_line), .badline(badline), .hires_en(hires_en),
    .idle(idle), .vc(vc), .vc_base(vc_base), .rc(rc), .row_start(row_start), .hvc(hvc)
  );

  // clock / reset
  always #5 clk_dot4x = ~clk_dot4x;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog expired");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk_dot4x);
    #1;
  endtask

  task automatic ev_e1(input int cyc, input int line, input logic bl);
    cycle_num = 7'(cyc);
    raster_line = 9'(line);
    badline = bl;
    clk_phi = 1'b1;
    phi_phase_start_1 = 1'b1;
    tick();
    // phase-1 strobe in the low phi half must be ignored, even at the load cycle
    clk_phi = 1'b0;
    cycle_num = 7'(C_LOAD);
    tick();
    phi_phase_start_1 = 1'b0;
    clk_phi = 1'b1;
  endtask

  task automatic ev_e8();
    cycle_num = 7'($urandom_range(0, 127));
    clk_phi = 1'b1;
    phi_phase_start_8 = 1'b1;
    tick();
    phi_phase_start_8 = 1'b0;
  endtask

  task automatic ev_e14(input logic bl);
    cycle_num = 7'($urandom_range(0, 127));
    badline = bl;
    clk_phi = 1'b1;
    phi_phase_start_14 = 1'b1;
    tick();
    phi_phase_start_14 = 1'b0;
  endtask

  task automatic run_cycles(input int line, input logic bl, input int first, input int last,
                            input int load_exp);
    for (int c = first; c <= last; c++) begin
      if (c == C_LOAD) load_q.push_back(VC_W'(load_exp));
      ev_e1(c, line, bl);
      ev_e8();
      ev_e14(bl);
    end
  endtask

  task automatic expect_val(input logic [3:0] sel, input int val, input string name);
    exp_q.push_back({sel, 12'(val)});
    name_q.push_back(name);
    chk_req = 1'b1;
    @(negedge clk_dot4x);
    #1;
    chk_req = 1'b0;
  endtask

  // scoreboard monitor
  always @(negedge clk_dot4x) begin
    logic [15:0] e;
    logic [11:0] act;
    string nm;
    if (row_start) begin
      checks++;
      if (load_q.size() == 0) begin
        errors++;
        $display("FAIL row_start: got pulse with vc=%0d expected no pulse", vc);
      end else begin
        logic [VC_W-1:0] le;
        le = load_q.pop_front();
        if (vc !== le) begin
          errors++;
          $display("FAIL load_vc: got %0d expected %0d", vc, le);
        end
      end
    end
    if (chk_req && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      nm = name_q.pop_front();
      case (e[15:12])
        SEL_VC:   act = 12'(vc);
        SEL_VCB:  act = 12'(vc_base);
        SEL_RC:   act = 12'(rc);
        SEL_IDLE: act = 12'(idle);
        default:  act = 12'(hvc);
      endcase
      checks++;
      if (act !== e[11:0]) begin
        errors++;
        $display("FAIL %s: got %0d expected %0d", nm, act, e[11:0]);
      end
    end
  end

  initial begin
    rst = 1'b1;
    clk_phi = 1'b0;
    phi_phase_start_1 = 1'b0;
    phi_phase_start_8 = 1'b0;
    phi_phase_start_14 = 1'b0;
    cycle_num = '0;
    raster_line = '0;
    badline = 1'b0;
    hires_en = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    expect_val(SEL_VC, 0, "rst_vc");
    expect_val(SEL_VCB, 0, "rst_vc_base");
    expect_val(SEL_RC, 7, "rst_rc");
    expect_val(SEL_IDLE, 1, "rst_idle");
    expect_val(SEL_HVC, 0, "rst_hvc");

    run_cycles(0, 1'b0, 1, 63, 0);

    // badline line: display, rc restart, 40 fetches
    run_cycles('h30, 1'b1, 1, 1, 0);
    expect_val(SEL_IDLE, 0, "bl_idle_e14");
    run_cycles('h30, 1'b1, 2, 13, 0);
    expect_val(SEL_RC, 0, "bl_rc_load");
    run_cycles('h30, 1'b1, 14, 54, 0);
    expect_val(SEL_VC, 40, "bl_vc_54");
    expect_val(SEL_HVC, HIRES ? 80 : 0, "bl_hvc_54");
    run_cycles('h30, 1'b1, 55, 63, 0);
    expect_val(SEL_RC, 1, "bl_rc_end");
    expect_val(SEL_IDLE, 0, "bl_idle_end");

    for (int l = 1; l <= 6; l++) begin
      run_cycles('h30 + l, 1'b0, 1, 63, 0);
      expect_val(SEL_RC, l + 1, "row_rc_step");
    end
    run_cycles('h37, 1'b0, 1, 63, 0);
    expect_val(SEL_VCB, 40, "row8_vc_base");
    expect_val(SEL_IDLE, 1, "row8_idle");
    expect_val(SEL_RC, 7, "row8_rc_hold");

    run_cycles('h38, 1'b0, 1, 63, 40);
    expect_val(SEL_VC, 40, "idle_vc_hold");
    expect_val(SEL_VCB, 40, "idle_vc_base");

    // badline arriving while rc sits at the last row
    run_cycles('h40, 1'b0, 1, 14, 40);
    run_cycles('h40, 1'b1, 15, 56, 40);
    ev_e1(57, 'h40, 1'b1);
    expect_val(SEL_VCB, 79, "wrapbl_vc_base");
    expect_val(SEL_RC, 0, "wrapbl_rc");
    expect_val(SEL_IDLE, 0, "wrapbl_idle");
    ev_e8();
    ev_e14(1'b1);
    run_cycles('h40, 1'b1, 58, 63, 40);

    // asynchronous reset in the middle of a frame
    #2;
    rst = 1'b1;
    expect_val(SEL_VC, 0, "mid_rst_vc");
    expect_val(SEL_VCB, 0, "mid_rst_vc_base");
    expect_val(SEL_RC, 7, "mid_rst_rc");
    expect_val(SEL_IDLE, 1, "mid_rst_idle");
    expect_val(SEL_HVC, 0, "mid_rst_hvc");
    rst = 1'b0;
    tick();

    // build vc_base = 1020 with a long run of window strobes
    ev_e14(1'b1);
    load_q.push_back(VC_W'(0));
    ev_e1(C_LOAD, 'h50, 1'b0);
    repeat (1020) ev_e1(15, 'h50, 1'b0);
    ev_e1(57, 'h50, 1'b0);
    expect_val(SEL_VCB, 1020, "pre_wrap_vc_base");
    expect_val(SEL_IDLE, 1, "pre_wrap_idle");
    expect_val(SEL_RC, 7, "pre_wrap_rc");

    hires_en = 1'b0;
    run_cycles('h51, 1'b1, 1, 54, 1020);
    expect_val(SEL_VC, 36, "wrap_vc");
    expect_val(SEL_HVC, HIRES ? 1020 : 0, "hires_off_hvc");
    hires_en = 1'b1;
    run_cycles('h51, 1'b1, 55, 63, 1020);
    expect_val(SEL_RC, 1, "wrap_rc_end");

    ev_e1(1, 0, 1'b0);
    expect_val(SEL_VC, 0, "frame_vc");
    expect_val(SEL_VCB, 0, "frame_vc_base");
    expect_val(SEL_HVC, 0, "frame_hvc");

    repeat (4) tick();
    checks++;
    if (load_q.size() != 0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL queues_drained: got %0d loads %0d checks pending expected 0", load_q.size(),
               exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
